// File: rtl/seq_recursive_mult.sv
// Iterative WIDTH x WIDTH multiplier: one (WIDTH/2)^2 sub-multiplier is time-shared over four
// quadrant products. Each quadrant can be truncated per transaction. RECMUL_ERR_CNT_EN adds an exact-vs-approx mismatch counter.
`timescale 1ns/1ps
module seq_recursive_mult #(
    parameter int WIDTH = 8,
    parameter int TRUNC = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [3:0]           approx_mask,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy
`ifdef RECMUL_ERR_CNT_EN
   ,output logic [15:0]          err_cnt
`endif
);
    localparam int H = WIDTH / 2;
    localparam logic [WIDTH-1:0] KEEP_MASK = {WIDTH{1'b1}} << TRUNC;

    typedef enum logic [2:0] {IDLE, Q0, Q1, Q2, Q3, DONE} state_t;

    state_t               state_reg, state_next;
    logic [WIDTH-1:0]     a_reg, b_reg;
    logic [3:0]           mask_reg;
    logic [2*WIDTH-1:0]   acc_reg, p_reg;
    logic                 accept;

    logic [H-1:0]         sub_a, sub_b;
    logic                 approx_sel;
    logic [WIDTH-1:0]     q_full, q_kept;
    logic [2*WIDTH-1:0]   q_ext, term, acc_sum;

    assign in_ready  = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg == Q0) || (state_reg == Q1) ||
                       (state_reg == Q2) || (state_reg == Q3);
    assign p         = p_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = Q0;
            Q0:      state_next = Q1;
            Q1:      state_next = Q2;
            Q2:      state_next = Q3;
            Q3:      state_next = DONE;
            DONE: begin
                if (out_ready) state_next = in_valid ? Q0 : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Quadrant operand routing: LL, HL, LH, HH in Q0..Q3.
    always_comb begin
        sub_a      = '0;
        sub_b      = '0;
        approx_sel = 1'b0;
        case (state_reg)
            Q0: begin sub_a = a_reg[H-1:0];     sub_b = b_reg[H-1:0];     approx_sel = mask_reg[0]; end
            Q1: begin sub_a = a_reg[WIDTH-1:H]; sub_b = b_reg[H-1:0];     approx_sel = mask_reg[1]; end
            Q2: begin sub_a = a_reg[H-1:0];     sub_b = b_reg[WIDTH-1:H]; approx_sel = mask_reg[2]; end
            Q3: begin sub_a = a_reg[WIDTH-1:H]; sub_b = b_reg[WIDTH-1:H]; approx_sel = mask_reg[3]; end
            default: ;
        endcase
    end

    assign q_full = WIDTH'(sub_a) * WIDTH'(sub_b);
    assign q_kept = approx_sel ? (q_full & KEEP_MASK) : q_full;
    assign q_ext  = {{WIDTH{1'b0}}, q_kept};

    always_comb begin
        term = '0;
        case (state_reg)
            Q0:      term = q_ext;
            Q1, Q2:  term = q_ext << H;
            Q3:      term = q_ext << WIDTH;
            default: ;
        endcase
    end

    assign acc_sum = acc_reg + term;

`ifdef RECMUL_ERR_CNT_EN
    logic [2*WIDTH-1:0] exact_reg, exact_term, exact_sum;
    logic [15:0]        err_cnt_reg;
    logic [2*WIDTH-1:0] qx_ext;

    assign qx_ext = {{WIDTH{1'b0}}, q_full};
    always_comb begin
        exact_term = '0;
        case (state_reg)
            Q0:      exact_term = qx_ext;
            Q1, Q2:  exact_term = qx_ext << H;
            Q3:      exact_term = qx_ext << WIDTH;
            default: ;
        endcase
    end
    assign exact_sum = exact_reg + exact_term;
    assign err_cnt   = err_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exact_reg   <= '0;
            err_cnt_reg <= '0;
        end else if (accept) begin
            exact_reg <= '0;
        end else if (busy) begin
            exact_reg <= exact_sum;
            // Compare final sums on the Q3 -> DONE edge; counter saturates.
            if ((state_reg == Q3) && (acc_sum != exact_sum) && (err_cnt_reg != 16'hFFFF))
                err_cnt_reg <= err_cnt_reg + 16'd1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            mask_reg <= '0;
            acc_reg  <= '0;
            p_reg    <= '0;
        end else if (accept) begin
            a_reg    <= a;
            b_reg    <= b;
            mask_reg <= approx_mask;
            acc_reg  <= '0;
        end else if (busy) begin
            acc_reg <= acc_sum;
            // p is a separate register so it survives the acc clear of a back-to-back accept.
            if (state_reg == Q3) p_reg <= acc_sum;
        end
    end
endmodule

// File: doc/seq_recursive_mult.md
Name: seq_recursive_mult

Overview:
- Iterative, parametrised successor to the combinational recursive 8x8 multipliers.
- A single WIDTH/2 x WIDTH/2 sub-multiplier is time-shared across the four quadrant products (LL, HL, LH, HH).
- Results accumulate with shifts into a 2*WIDTH product.
- Each quadrant is selected exact or approximate (low-column truncation) per transaction, so the accuracy/area trade-offs of the recursive family can be explored at run time behind a valid/ready interface.

Parameters:
- WIDTH, 8, operand width; even, >= 4. H = WIDTH/2.
- TRUNC, 2, number of LSBs zeroed in an approximate quadrant product; 0 <= TRUNC <= WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and mask valid.
- in_ready  output  1  block can accept an operand pair.
- a  input  WIDTH  multiplicand, unsigned.
- b  input  WIDTH  multiplier, unsigned.
- approx_mask  input  4  per-quadrant approximate enable: bit0 LL (A_L*B_L), bit1 HL (A_H*B_L), bit2 LH (A_L*B_H), bit3 HH (A_H*B_H).
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- p  output  2*WIDTH  product.
- busy  output  1  high in Q0..Q3.
- err_cnt  output  16  only with RECMUL_ERR_CNT_EN.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; acc, operand and mask registers cleared.
  - p=0, out_valid=0, busy=0, in_ready=1, err_cnt=0.
  - Reset mid-operation abandons the transaction; no output is produced.
- FSM states and transitions:
  - IDLE -> Q0 on in_valid&in_ready.
  - Q0 -> Q1 -> Q2 -> Q3 -> DONE unconditionally.
  - DONE: out_ready&in_valid -> Q0 (back-to-back accept); out_ready&!in_valid -> IDLE; !out_ready -> stay.
- Handshakes:
  - in_ready = (state==IDLE) | (state==DONE & out_ready), combinational.
  - On accept: a, b and approx_mask are registered and acc cleared. Input changes after accept have no effect.
- Quadrant step, per state (shift): Q0 LL (0), Q1 HL (H), Q2 LH (H), Q3 HH (WIDTH).
  - q = sub_a*sub_b, a full WIDTH-bit product.
  - If the state's mask bit is set: q = q & ~((1<<TRUNC)-1).
  - acc <= acc + (q << shift).
- Width: acc is 2*WIDTH bits and never overflows, because the approximate result is always <= the exact result.
- Latency: out_valid rises on the 4th rising edge after the accepting edge. p = acc while out_valid=1.
- Output hold: p and out_valid hold while out_valid & !out_ready.
- out_valid falls on the out_ready edge unless a new transaction is accepted on that same edge. In that case out_valid falls and Q0 starts.
- p retains its last value when out_valid=0.
- Exact mode: mask=0 gives p = a*b for all operands, including 0 and all-ones.
- TRUNC=0: approximate equals exact.

Optional Feature:
- Macro: RECMUL_ERR_CNT_EN.
- Defined:
  - A shadow exact accumulator runs in parallel using untruncated q.
  - On entry to DONE, err_cnt increments if acc != exact accumulator.
  - err_cnt is 16-bit, saturates at 0xFFFF and clears only on reset.
- Undefined: err_cnt port, shadow accumulator and counter are absent; remaining behaviour is unchanged.

Test Plan:
- WIDTH=8, reset, then a=255, b=255, mask=0 -> out_valid 4 cycles after accept, p=65025. Also a=0, b=200 -> p=0.
- a=55, b=91, mask=4'b0001 -> p=5004. Same operands with mask=4'b1111 -> p=4172 (exact 5005). With RECMUL_ERR_CNT_EN, err_cnt=2 after both.
- Backpressure: a=12, b=13, out_ready=0 for 6 cycles -> p=156 and out_valid stay stable, in_ready=0. Raise out_ready with in_valid held (a=3, b=4) -> back-to-back accept, next p=12.
- Reset mid-operation: assert rst_n=0 in Q2 -> all outputs return to reset values immediately. After release, a=10, b=10, mask=0 -> p=100 with no stale data.
- Randomised exact check over 1000 pairs with mask=0 -> p==a*b every time. Repeat with WIDTH=16 and TRUNC=4, mask=4'b1000: p == a*b - ((A_H*B_H) mod 16)<<16.
